voice_allocator: RTL and testbench

- Dynamic voice scheduler between a single-stream note source and the three-voice chord player.
- Accepts one note request at a time (note, duration) over a valid/ready handshake.
- Assigns each request to a free chord-player voice, issues that voice's load pulse, and tracks busy state from the per-voice done pulses.
- Frees the song source from hard-wiring notes to specific voices.

---
 rtl/voice_allocator.sv | 116 +++++++++++
 tb/tb_voice_allocator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Dynamic voice scheduler: routes single-stream note requests onto three chord-player voices.
// Optional build macro VOICE_STEAL_EN: with every voice busy, a note overwrites the oldest voice.
module voice_allocator #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              req_valid,
  input  logic [NOTE_W-1:0] req_note,
  input  logic [DUR_W-1:0]  req_duration,
  output logic              req_ready,
  output logic [NOTE_W-1:0] note1,
  output logic [NOTE_W-1:0] note2,
  output logic [NOTE_W-1:0] note3,
  output logic [DUR_W-1:0]  duration1,
  output logic [DUR_W-1:0]  duration2,
  output logic [DUR_W-1:0]  duration3,
  output logic              new_note1,
  output logic              new_note2,
  output logic              new_note3,
  input  logic              note_done1,
  input  logic              note_done2,
  input  logic              note_done3,
  output logic [2:0]        busy,
  output logic              all_idle
);

  logic [2:0]        busy_q;
  logic [2:0]        new_q;
  logic [1:0]        rank_q [3];
  logic [NOTE_W-1:0] note_q [3];
  logic [DUR_W-1:0]  dur_q  [3];

  logic [2:0] free;
  logic [2:0] done;
  logic [2:0] sel;
  logic [2:0] load;
  logic [1:0] old_rank;
  logic       is_rest;
  logic       accept;

  assign free    = ~busy_q;
  assign done    = {note_done3, note_done2, note_done1};
  assign is_rest = (req_note == '0);

`ifdef VOICE_STEAL_EN
  // Rests and free voices are always acceptable, and a full allocation steals.
  assign req_ready = play;
`else
  assign req_ready = play & (is_rest | (|free));
`endif

  assign accept = req_valid & req_ready;

  always_comb begin
    sel = 3'b000;
    if (free[0])      sel = 3'b001;
    else if (free[1]) sel = 3'b010;
    else if (free[2]) sel = 3'b100;
`ifdef VOICE_STEAL_EN
    else begin
      for (int i = 0; i < 3; i++)
        if (rank_q[i] == 2'd2) sel[i] = 1'b1;
    end
`endif
  end

  assign load = (accept && !is_rest) ? sel : 3'b000;

  always_comb begin
    old_rank = 2'd0;
    for (int i = 0; i < 3; i++)
      if (load[i]) old_rank = rank_q[i];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 3'b000;
      new_q  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        rank_q[i] <= 2'(i);
        note_q[i] <= '0;
        dur_q[i]  <= '0;
      end
    end else begin
      // A load on the same voice as its done pulse keeps the voice allocated.
      busy_q <= (busy_q & ~done) | load;
      new_q  <= load;
      for (int i = 0; i < 3; i++) begin
        if (load[i]) begin
          note_q[i] <= req_note;
          dur_q[i]  <= req_duration;
        end
        if (|load) begin
          if (load[i])                   rank_q[i] <= 2'd0;
          else if (rank_q[i] < old_rank) rank_q[i] <= rank_q[i] + 2'd1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign all_idle  = (busy_q == 3'b000);
  assign note1     = note_q[0];
  assign note2     = note_q[1];
  assign note3     = note_q[2];
  assign duration1 = dur_q[0];
  assign duration2 = dur_q[1];
  assign duration3 = dur_q[2];
  assign new_note1 = new_q[0];
  assign new_note2 = new_q[1];
  assign new_note3 = new_q[2];

endmodule

// File: tb/tb_voice_allocator.sv
// Table-driven bench for voice_allocator plus a hand-written stall/steal sequence.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       reset, play, req_valid, req_ready;
  logic [5:0] req_note, req_duration;
  logic [5:0] note1, note2, note3, duration1, duration2, duration3;
  logic       new_note1, new_note2, new_note3;
  logic       note_done1, note_done2, note_done3;
  logic [2:0] busy;
  logic       all_idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  voice_allocator #(.NOTE_W(6), .DUR_W(6)) dut (
    .clk(clk), .reset(reset), .play(play),
    .req_valid(req_valid), .req_note(req_note), .req_duration(req_duration),
    .req_ready(req_ready),
    .note1(note1), .note2(note2), .note3(note3),
    .duration1(duration1), .duration2(duration2), .duration3(duration3),
    .new_note1(new_note1), .new_note2(new_note2), .new_note3(new_note3),
    .note_done1(note_done1), .note_done2(note_done2), .note_done3(note_done3),
    .busy(busy), .all_idle(all_idle)
  );

  typedef struct packed {
    logic        rst_b;
    logic        play;
    logic        valid;
    logic [5:0]  note;
    logic [5:0]  dur;
    logic [2:0]  done;
    logic        chk_ready;
    logic        exp_ready;
    logic [2:0]  exp_busy;
    logic [2:0]  exp_new;
    logic [17:0] exp_notes;
    logic [17:0] exp_durs;
  } vec_t;

  function automatic vec_t mk(logic rst_b, logic pl, logic v, logic [5:0] n, logic [5:0] d,
                              logic [2:0] dn, logic cr, logic er, logic [2:0] eb,
                              logic [2:0] en, logic [17:0] ens, logic [17:0] eds);
    vec_t r;
    r = {rst_b, pl, v, n, d, dn, cr, er, eb, en, ens, eds};
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  vec_t        tbl [16];
  logic [17:0] en7, ed7;
  logic        seen;

  initial begin
    // Expected {n3,n2,n1} / {d3,d2,d1} after the all-busy phase.
`ifdef VOICE_STEAL_EN
    en7 = {6'd42, 6'd41, 6'd40};
    ed7 = {6'd3,  6'd2,  6'd7};
`else
    en7 = {6'd30, 6'd40, 6'd10};
    ed7 = {6'd6,  6'd7,  6'd4};
`endif
    tbl[0]  = mk(0, 0, 1, 10, 4, 3'b000, 1, 0, 3'b000, 3'b000, 18'd0, 18'd0);
    tbl[1]  = mk(0, 0, 1, 10, 4, 3'b000, 1, 0, 3'b000, 3'b000, 18'd0, 18'd0);
    tbl[2]  = mk(1, 1, 1, 10, 4, 3'b000, 1, 1, 3'b001, 3'b001, {6'd0, 6'd0, 6'd10}, {6'd0, 6'd0, 6'd4});
    tbl[3]  = mk(1, 1, 1, 20, 5, 3'b000, 1, 1, 3'b011, 3'b010, {6'd0, 6'd20, 6'd10}, {6'd0, 6'd5, 6'd4});
    tbl[4]  = mk(1, 1, 1, 30, 6, 3'b000, 1, 1, 3'b111, 3'b100, {6'd30, 6'd20, 6'd10}, {6'd6, 6'd5, 6'd4});
`ifdef VOICE_STEAL_EN
    tbl[5]  = mk(1, 1, 1, 40, 7, 3'b000, 1, 1, 3'b111, 3'b001, {6'd30, 6'd20, 6'd40}, {6'd6, 6'd5, 6'd7});
    tbl[6]  = mk(1, 1, 1, 41, 2, 3'b000, 1, 1, 3'b111, 3'b010, {6'd30, 6'd41, 6'd40}, {6'd6, 6'd2, 6'd7});
    tbl[7]  = mk(1, 1, 1, 42, 3, 3'b100, 1, 1, 3'b111, 3'b100, en7, ed7);
`else
    tbl[5]  = mk(1, 1, 1, 40, 7, 3'b000, 1, 0, 3'b111, 3'b000, {6'd30, 6'd20, 6'd10}, {6'd6, 6'd5, 6'd4});
    tbl[6]  = mk(1, 1, 1, 40, 7, 3'b010, 1, 0, 3'b101, 3'b000, {6'd30, 6'd20, 6'd10}, {6'd6, 6'd5, 6'd4});
    tbl[7]  = mk(1, 1, 1, 40, 7, 3'b000, 1, 1, 3'b111, 3'b010, en7, ed7);
`endif
    tbl[8]  = mk(1, 1, 1, 0,  0, 3'b000, 1, 1, 3'b111, 3'b000, en7, ed7);
    tbl[9]  = mk(1, 0, 1, 50, 1, 3'b001, 1, 0, 3'b110, 3'b000, en7, ed7);
    tbl[10] = mk(1, 0, 1, 50, 1, 3'b000, 1, 0, 3'b110, 3'b000, en7, ed7);
    tbl[11] = mk(1, 0, 0, 0,  0, 3'b100, 1, 0, 3'b010, 3'b000, en7, ed7);
    tbl[12] = mk(1, 0, 0, 0,  0, 3'b100, 1, 0, 3'b010, 3'b000, en7, ed7);
    tbl[13] = mk(1, 1, 1, 50, 1, 3'b000, 1, 1, 3'b011, 3'b001, {en7[17:6], 6'd50}, {ed7[17:6], 6'd1});
    tbl[14] = mk(0, 1, 0, 0,  0, 3'b000, 0, 0, 3'b000, 3'b000, 18'd0, 18'd0);
    tbl[15] = mk(1, 1, 0, 0,  0, 3'b000, 1, 1, 3'b000, 3'b000, 18'd0, 18'd0);

    reset = 1'b0; play = 1'b0; req_valid = 1'b0; req_note = '0; req_duration = '0;
    {note_done3, note_done2, note_done1} = 3'b000;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      reset        = tbl[i].rst_b;
      play         = tbl[i].play;
      req_valid    = tbl[i].valid;
      req_note     = tbl[i].note;
      req_duration = tbl[i].dur;
      {note_done3, note_done2, note_done1} = tbl[i].done;
      #1;
      if (tbl[i].chk_ready) check($sformatf("req_ready[%0d]", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("busy[%0d]", i), 32'(busy), 32'(tbl[i].exp_busy));
      check($sformatf("new_note[%0d]", i), 32'({new_note3, new_note2, new_note1}), 32'(tbl[i].exp_new));
      check($sformatf("all_idle[%0d]", i), 32'(all_idle), 32'(tbl[i].exp_busy == 3'b000));
      check($sformatf("notes[%0d]", i), 32'({note3, note2, note1}), 32'(tbl[i].exp_notes));
      check($sformatf("durs[%0d]", i), 32'({duration3, duration2, duration1}), 32'(tbl[i].exp_durs));
    end

    // Fill all voices, then hold a fourth request while voice 1 retires.
    {note_done3, note_done2, note_done1} = 3'b000;
    req_valid = 1'b1; req_note = 6'd7; req_duration = 6'd9;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("fill_new[%0d]", k), 32'({new_note3, new_note2, new_note1}), 32'(3'b001 << k));
    end
    note_done1 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      note_done1 = 1'b0;
      if (new_note1) seen = 1'b1;
    end
    req_valid = 1'b0;
    check("reload_voice1_seen", 32'(seen), 32'(1));
    check("reload_note1", 32'(note1), 32'(7));
    check("reload_busy", 32'(busy), 32'(3'b111));
    @(posedge clk); #1;
    check("reload_pulse_end", 32'({new_note3, new_note2, new_note1}), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
